// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and result type for the full_adder slice.
//   FA_MAX_WIDTH  - widest legal operand width
//   fa_result_t   - {carry, sum} result at the widest width; instances that
//                   need an exact-width result declare their own copy sized
//                   by a local WIDTH-derived localparam.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  typedef struct packed {
    logic                    carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational one-bit full adder.
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out (majority of a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder built from fa_cell, optionally registered.
//   clk, rst_n          - clock / async active-low reset (unused if REGISTERED=0)
//   in_valid            - operands valid this cycle
//   augend, addend      - WIDTH-bit unsigned operands
//   carry_in            - carry into bit 0
//   sum, carry_out      - {carry_out, sum} = augend + addend + carry_in
//   out_valid           - sum/carry_out valid
// REGISTERED=1: 1-cycle latency, results only update on in_valid, outputs
// hold otherwise. REGISTERED=0: fully combinational, out_valid = in_valid.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  localparam int RES_W = WIDTH + 1;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } res_t;

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range 1..FA_MAX_WIDTH");
  end

  // Ripple chain: c[i] feeds bit i, c[WIDTH] is the final carry.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (augend[i]),
      .b    (addend[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  res_t res_c;
  assign res_c = '{carry: c[WIDTH], sum: s};

  if (REGISTERED) begin : g_reg
    res_t res_q;
    logic vld_q;

    // Result register only loads on valid so outputs hold across bubbles;
    // valid register follows in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= in_valid;
        if (in_valid) res_q <= res_c;
      end
    end

    assign sum       = res_q.sum;
    assign carry_out = res_q.carry;
    assign out_valid = vld_q;
  end else begin : g_comb
    // clk/rst_n have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum       = res_c.sum;
    assign carry_out = res_c.carry;
    assign out_valid = in_valid;
  end

  // RES_W documents the exact result width carried by res_t.
  if ($bits(res_t) != RES_W) begin : g_bad_res
    $error("full_adder: result width mismatch");
  end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic       clk;
  logic       rst_n;
  logic       vin;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;

  logic       s1, co1, ov1;
  logic [3:0] s4;
  logic       co4, ov4;
  logic [7:0] s8, s8c;
  logic       co8, ov8, co8c, ov8c;

  int n_tests = 0;
  int n_fail  = 0;

  full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin), .augend(a[0]), .addend(b[0]),
    .carry_in(cin), .sum(s1), .carry_out(co1), .out_valid(ov1));

  full_adder #(.WIDTH(4), .REGISTERED(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin), .augend(a[3:0]), .addend(b[3:0]),
    .carry_in(cin), .sum(s4), .carry_out(co4), .out_valid(ov4));

  full_adder #(.WIDTH(8), .REGISTERED(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin), .augend(a), .addend(b),
    .carry_in(cin), .sum(s8), .carry_out(co8), .out_valid(ov8));

  full_adder #(.WIDTH(8), .REGISTERED(1'b0)) u8c (
    .clk(clk), .rst_n(rst_n), .in_valid(vin), .augend(a), .addend(b),
    .carry_in(cin), .sum(s8c), .carry_out(co8c), .out_valid(ov8c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic cin;
    logic a;
    logic b;
    logic cout;
    logic s;
  } tt_t;

  tt_t tt [8];

  logic [8:0] exp_res;
  logic       exp_vld;
  logic [7:0] pa, pb;
  logic       pcin, pvin;

  initial begin
    // 1-bit truth table (cin,a,b -> cout,sum)
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    vin   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    // Reset state
    #3;
    chk("rst_s1", s1, 0);   chk("rst_co1", co1, 0);  chk("rst_ov1", ov1, 0);
    chk("rst_s8", s8, 0);   chk("rst_co8", co8, 0);  chk("rst_ov8", ov8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table, back-to-back at full throughput
    for (int i = 0; i < 8; i++) begin
      a[0] = tt[i].a;
      b[0] = tt[i].b;
      cin  = tt[i].cin;
      vin  = 1'b1;
      cyc();
      chk($sformatf("tt%0d_sum", i), s1, tt[i].s);
      chk($sformatf("tt%0d_cout", i), co1, tt[i].cout);
      chk($sformatf("tt%0d_vld", i), ov1, 1);
    end

    // 4-bit: full ripple and no-carry
    a = 8'h0F; b = 8'h00; cin = 1'b1; vin = 1'b1;
    cyc();
    chk("w4_ripple_sum", s4, 4'h0);
    chk("w4_ripple_cout", co4, 1);
    a = 8'h09; b = 8'h06; cin = 1'b0;
    cyc();
    chk("w4_9p6_sum", s4, 4'hF);
    chk("w4_9p6_cout", co4, 0);

    // Hold on in_valid=0
    a = 8'h01; b = 8'h01; cin = 1'b0; vin = 1'b1;
    cyc();
    chk("hold_cap_sum", s1, 0);
    chk("hold_cap_cout", co1, 1);
    chk("hold_cap_vld", ov1, 1);
    vin = 1'b0; a = 8'h00; b = 8'h00;
    cyc();
    chk("hold_sum", s1, 0);
    chk("hold_cout", co1, 1);
    chk("hold_vld", ov1, 0);
    cyc();
    chk("hold2_cout", co1, 1);

    // Async reset mid-cycle
    a = 8'h01; b = 8'h01; cin = 1'b1; vin = 1'b1;
    cyc();
    chk("pre_rst_sum", s1, 1);
    chk("pre_rst_cout", co1, 1);
    chk("pre_rst_vld", ov1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", s1, 0);
    chk("arst_cout", co1, 0);
    chk("arst_vld", ov1, 0);
    cyc();  // edge while in reset with valid inputs: must be ignored
    chk("in_rst_sum", s1, 0);
    chk("in_rst_vld", ov1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h01; b = 8'h00; cin = 1'b0; vin = 1'b1;
    cyc();
    chk("post_rst_sum", s1, 1);
    chk("post_rst_cout", co1, 0);
    chk("post_rst_vld", ov1, 1);

    // Combinational build
    a = 8'hFF; b = 8'h01; cin = 1'b0; vin = 1'b1;
    #1;
    chk("comb_sum", s8c, 8'h00);
    chk("comb_cout", co8c, 1);
    chk("comb_vld1", ov8c, 1);
    vin = 1'b0;
    #1;
    chk("comb_vld0", ov8c, 0);

    // Align to a cycle boundary, then prime the model from a known capture.
    cyc();
    a = 8'h00; b = 8'h00; cin = 1'b0; vin = 1'b1;
    cyc();
    exp_res = 9'd0;
    exp_vld = 1'b1;
    chk("rnd_prime_sum", s8, 0);

    // Random: 8-bit model of a+b+cin at one-cycle latency with hold
    for (int i = 0; i < 1000; i++) begin
      pa   = 8'($urandom);
      pb   = 8'($urandom);
      pcin = 1'($urandom);
      pvin = ($urandom_range(0, 3) != 0);
      a = pa; b = pb; cin = pcin; vin = pvin;
      #1;
      chk("rnd_comb", {co8c, s8c}, 9'(pa) + 9'(pb) + 9'(pcin));
      cyc();
      if (pvin) exp_res = 9'(pa) + 9'(pb) + 9'(pcin);
      exp_vld = pvin;
      chk("rnd_reg", {co8, s8}, exp_res);
      chk("rnd_vld", ov8, exp_vld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
